bus_transfer_sequencer: RTL and testbench

- Master sequencer for the shared tri-state register bus in the CPU datapath.
- Register flip-flops release the bus when their cs input is 1 and load on ClockEnable&Tick.
- This block drives the other end of that interface. It selects one source register to drive the bus, lets the bus settle, pulses the destination register's load enable, then releases the bus.
- It sequences register-to-register moves requested by the control unit, using a req/busy/done handshake.

---
 rtl/bus_transfer_sequencer_if.sv | 30 +++
 rtl/bus_transfer_sequencer.sv | 114 +++++++++++
 tb/tb_bus_transfer_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_sequencer_if.sv
// Handshake and register-bus signals between the control unit, the bus
// sequencer and the registers hanging off the shared tri-state bus.
interface bus_transfer_sequencer_if #(
  parameter int unsigned NrOfBits = 8,
  parameter int unsigned NrOfRegs = 4,
  parameter int unsigned SelBits  = 2
);
  logic                req;
  logic [SelBits-1:0]  src_sel;
  logic [SelBits-1:0]  dst_sel;
  logic [NrOfBits-1:0] bus_in;
  logic [NrOfRegs-1:0] cs;
  logic [NrOfRegs-1:0] load_en;
  logic                busy;
  logic                done;
  logic                err;
  logic [NrOfBits-1:0] captured;

  // Control-unit / register side
  modport master (
    output req, src_sel, dst_sel, bus_in,
    input  cs, load_en, busy, done, err, captured
  );

  // Sequencer side
  modport slave (
    input  req, src_sel, dst_sel, bus_in,
    output cs, load_en, busy, done, err, captured
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Master sequencer for the shared register bus: drive source, let the bus
// settle, pulse the destination load enable, release, then report done.
module bus_transfer_sequencer #(
  parameter int unsigned NrOfBits     = 8,
  parameter int unsigned NrOfRegs     = 4,
  parameter int unsigned SelBits      = 2,
  parameter int          SettleCycles = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Tick,
  bus_transfer_sequencer_if.slave  bus
);

  localparam int unsigned SettleEff = (SettleCycles < 1) ? 32'd1 : 32'(SettleCycles);
  localparam int unsigned CntBits   = (SettleEff > 1) ? $clog2(SettleEff) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LOAD,
    ST_RELEASE,
    ST_FINISH
  } state_t;

  state_t              state;
  logic [CntBits-1:0]  cnt;
  logic [SelBits-1:0]  dst_q;
  logic [NrOfRegs-1:0] cs_q;
  logic [NrOfRegs-1:0] load_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [NrOfBits-1:0] captured_q;
  logic                sel_bad;

  function automatic logic [NrOfRegs-1:0] one_hot(input logic [SelBits-1:0] sel);
    logic [NrOfRegs-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      v[i] = (32'(sel) == i);
    end
    return v;
  endfunction

  assign sel_bad = (32'(bus.src_sel) >= NrOfRegs) || (32'(bus.dst_sel) >= NrOfRegs);

  // Sequencer FSM; the source select lives on only as the registered cs pattern
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dst_q      <= '0;
      cs_q       <= '1;
      load_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      captured_q <= '0;
    end else if (Tick) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req) begin
            dst_q  <= bus.dst_sel;
            busy_q <= 1'b1;
            if (sel_bad) begin
              state  <= ST_FINISH;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state <= ST_DRIVE;
              cnt   <= CntBits'(SettleEff - 1);
              cs_q  <= ~one_hot(bus.src_sel);
            end
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            state  <= ST_LOAD;
            load_q <= one_hot(dst_q);
          end else begin
            cnt <= cnt - CntBits'(1);
          end
        end
        ST_LOAD: begin
          state      <= ST_RELEASE;
          load_q     <= '0;
          cs_q       <= '1;
          captured_q <= bus.bus_in;
        end
        ST_RELEASE: begin
          state  <= ST_FINISH;
          done_q <= 1'b1;
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are masked while Tick is low so a frozen LOAD/FINISH never repeats them
  assign bus.cs       = cs_q;
  assign bus.load_en  = Tick ? load_q : '0;
  assign bus.done     = done_q & Tick;
  assign bus.err      = err_q & Tick;
  assign bus.busy     = busy_q;
  assign bus.captured = captured_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Randomized and directed bench for bus_transfer_sequencer, two configurations
// driven in lockstep and checked against a transfer-schedule model.
module tb_bus_transfer_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Tick;
  logic       req;
  logic [1:0] src_sel;
  logic [1:0] dst_sel;
  logic [7:0] bus_in;

  int n_checks = 0;
  int n_errors = 0;

  bus_transfer_sequencer_if #(.NrOfBits(8), .NrOfRegs(4), .SelBits(2)) if0 ();
  bus_transfer_sequencer_if #(.NrOfBits(8), .NrOfRegs(3), .SelBits(2)) if1 ();

  assign if0.req = req;
  assign if0.src_sel = src_sel;
  assign if0.dst_sel = dst_sel;
  assign if0.bus_in = bus_in;
  assign if1.req = req;
  assign if1.src_sel = src_sel;
  assign if1.dst_sel = dst_sel;
  assign if1.bus_in = bus_in;

  bus_transfer_sequencer #(.NrOfBits(8), .NrOfRegs(4), .SelBits(2), .SettleCycles(1)) dut0 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .bus(if0)
  );
  bus_transfer_sequencer #(.NrOfBits(8), .NrOfRegs(3), .SelBits(2), .SettleCycles(3)) dut1 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .bus(if1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: a transfer is a count of Ticks since its req was accepted
  int unsigned m_regs   [2] = '{4, 3};
  int unsigned m_settle [2] = '{1, 3};
  bit          m_act    [2];
  bit          m_err    [2];
  int unsigned m_ph     [2];
  int unsigned m_src    [2];
  int unsigned m_dst    [2];
  logic [7:0]  m_cap    [2];

  function automatic int unsigned fin_ph(input int d);
    return m_err[d] ? 1 : m_settle[d] + 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (Reset) begin
        m_act[d] = 1'b0;
        m_cap[d] = 8'h00;
      end else if (Tick) begin
        if (m_act[d]) begin
          if (!m_err[d] && m_ph[d] == m_settle[d] + 1) m_cap[d] = bus_in;
          if (m_ph[d] == fin_ph(d)) m_act[d] = 1'b0;
          else m_ph[d]++;
        end else if (req) begin
          m_act[d] = 1'b1;
          m_ph[d]  = 1;
          m_src[d] = 32'(src_sel);
          m_dst[d] = 32'(dst_sel);
          m_err[d] = (m_src[d] >= m_regs[d]) || (m_dst[d] >= m_regs[d]);
        end
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [31:0] cs, input logic [31:0] ld,
                           input logic [31:0] busy, input logic [31:0] done,
                           input logic [31:0] err, input logic [31:0] cap);
    logic [31:0] mask, e_cs, e_ld;
    bit xfer, e_done;
    mask   = (32'd1 << m_regs[d]) - 32'd1;
    xfer   = m_act[d] && !m_err[d];
    e_cs   = (xfer && m_ph[d] <= m_settle[d] + 1) ? (~(32'd1 << m_src[d]) & mask) : mask;
    e_ld   = (xfer && m_ph[d] == m_settle[d] + 1 && Tick) ? (32'd1 << m_dst[d]) : 32'd0;
    e_done = m_act[d] && m_ph[d] == fin_ph(d) && Tick;
    check($sformatf("d%0d cs", d), cs, e_cs);
    check($sformatf("d%0d load_en", d), ld, e_ld);
    check($sformatf("d%0d busy", d), busy, 32'(m_act[d]));
    check($sformatf("d%0d done", d), done, 32'(e_done));
    check($sformatf("d%0d err", d), err, 32'(e_done && m_err[d]));
    check($sformatf("d%0d captured", d), cap, 32'(m_cap[d]));
  endtask

  task automatic cycle(input logic r, input logic t, input logic q,
                       input logic [1:0] s, input logic [1:0] dd, input logic [7:0] b);
    Reset = r; Tick = t; req = q; src_sel = s; dst_sel = dd; bus_in = b;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    check_dut(0, 32'(if0.cs), 32'(if0.load_en), 32'(if0.busy), 32'(if0.done),
              32'(if0.err), 32'(if0.captured));
    check_dut(1, 32'(if1.cs), 32'(if1.load_en), 32'(if1.busy), 32'(if1.done),
              32'(if1.err), 32'(if1.captured));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);

    // src=1 dst=3 with 8'hA5 on the bus (out of range for the 3-register copy)
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 2'd3, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 8'hA5);
    check("t1 captured", 32'(if0.captured), 32'hA5);

    // src=0 dst=2, long settle on the second copy
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 8'h3C);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 8'h3C);
    check("t2 captured", 32'(if1.captured), 32'h3C);

    // Tick toggling mid-transfer
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 8'h5A);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'((i % 2) == 1), 1'b0, 2'd1, 2'd2, 8'h5A);
    idle(3);

    // Out-of-range source
    cycle(1'b0, 1'b1, 1'b1, 2'd3, 2'd1, 8'h77);
    idle(7);

    // Reset during DRIVE, then a fresh transfer
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 8'h11);
    cycle(1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 8'h11);
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 8'h22);
    idle(7);

    // req held high with changing selects
    for (int i = 0; i < 30; i++)
      cycle(1'b0, 1'b1, 1'b1, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 8'($urandom));
    idle(7);

    // Fully random traffic
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(49, 0) == 0), 1'($urandom_range(3, 0) != 0),
            1'($urandom_range(2, 0) == 0), 2'($urandom_range(3, 0)),
            2'($urandom_range(3, 0)), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
